// File: rtl/ui_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ui_pkg                                                         |
// | Brief    : Shared types and constants for the user-interface blocks      |
// |            (button conditioning, display scanning).                      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package ui_pkg;

    // Default prescale for a 1 ms sample tick from a 50 MHz clock.
    localparam int TICK_1MS = 50000;

    // Auto-repeat sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } state_t;

    // Counter width able to hold 0..term-1; never narrower than one bit.
    function automatic int cnt_width(input int term);
        return (term > 1) ? $clog2(term) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tick_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tick_gen                                                       |
// | Brief    : Free-running prescaler producing a one-cycle tick every       |
// |            TICK_DIV clk cycles.                                          |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tick_gen
    import ui_pkg::*;
#(
    parameter int TICK_DIV = TICK_1MS
) (
    input  logic clk,
    input  logic clr,
    output logic tick
);

    localparam int             c_W    = cnt_width(TICK_DIV);
    localparam logic [c_W-1:0] c_LAST = c_W'(TICK_DIV - 1);

    logic [c_W-1:0] r_cnt;

    // Count 0..TICK_DIV-1 and wrap; the terminal count is the tick cycle.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_cnt <= '0;
        end else if (r_cnt == c_LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign tick = (r_cnt == c_LAST);

endmodule
`default_nettype wire

// File: rtl/debounce_pulse.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : debounce_pulse                                                 |
// | Brief    : Synchronises and debounces a raw push-button, emitting one    |
// |            clk-wide pulse per press plus optional auto-repeat pulses.    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module debounce_pulse
    import ui_pkg::*;
#(
    parameter int TICK_DIV     = TICK_1MS,
    parameter int STABLE_CNT   = 8,
    parameter int ACTIVE_LOW   = 1,
    parameter int REPEAT_EN    = 1,
    parameter int REPEAT_DELAY = 500,
    parameter int REPEAT_RATE  = 100
) (
    input  logic clk,
    input  logic clr,
    input  logic btn_n,
    output logic level,
    output logic pulse,
    output logic rpt
);

    // Raw pin value that means "not pressed".
    localparam logic c_RELEASED = (ACTIVE_LOW != 0);
    localparam logic c_REP_EN   = (REPEAT_EN != 0);

    localparam int c_STAB_W   = cnt_width(STABLE_CNT);
    localparam int c_RCNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int c_RCNT_W   = cnt_width(c_RCNT_MAX);

    localparam logic [c_STAB_W-1:0] c_STAB_LAST  = c_STAB_W'(STABLE_CNT - 1);
    localparam logic [c_RCNT_W-1:0] c_DELAY_LAST = c_RCNT_W'(REPEAT_DELAY - 1);
    localparam logic [c_RCNT_W-1:0] c_RATE_LAST  = c_RCNT_W'(REPEAT_RATE - 1);

    logic                r_sync_a;
    logic                r_sync_b;
    logic                w_s;
    logic                w_tick;

    logic [c_STAB_W-1:0] r_stab;
    logic                r_level;
    logic                w_differ;
    logic                w_toggle;
    logic                w_rise;
    logic                w_fall;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_RCNT_W-1:0] r_rcnt;
    logic [c_RCNT_W-1:0] w_rcnt_nxt;
    logic                r_pulse;
    logic                w_pulse_nxt;
    logic                r_rpt;
    logic                w_rpt_nxt;

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .clr  (clr),
        .tick (w_tick)
    );

    // Two-flop synchroniser, parked at the released level so reset never looks like a press.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_sync_a <= c_RELEASED;
            r_sync_b <= c_RELEASED;
        end else begin
            r_sync_a <= btn_n;
            r_sync_b <= r_sync_a;
        end
    end

    // Normalised sample: 1 = pressed regardless of pin polarity.
    assign w_s = r_sync_b ^ c_RELEASED;

    // The level flips on the tick whose disagreeing sample completes the stable run.
    assign w_differ = w_s ^ r_level;
    assign w_toggle = w_tick & w_differ & (r_stab == c_STAB_LAST);
    assign w_rise   = w_toggle & ~r_level;
    assign w_fall   = w_toggle &  r_level;

    // Stability integrator: any agreeing sample restarts the run.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_stab  <= '0;
            r_level <= 1'b0;
        end else if (w_tick) begin
            if (!w_differ) begin
                r_stab <= '0;
            end else if (r_stab == c_STAB_LAST) begin
                r_stab  <= '0;
                r_level <= ~r_level;
            end else begin
                r_stab <= r_stab + 1'b1;
            end
        end
    end

    // Sequencer registers; pulse/rpt are registered so they share the level-rise edge.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state <= ST_IDLE;
            r_rcnt  <= '0;
            r_pulse <= 1'b0;
            r_rpt   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_rcnt  <= w_rcnt_nxt;
            r_pulse <= w_pulse_nxt;
            r_rpt   <= w_rpt_nxt;
        end
    end

    // Next-state and strobe decode; a falling level overrides any repeat due on the same tick.
    always_comb begin
        w_state_nxt = r_state;
        w_rcnt_nxt  = r_rcnt;
        w_pulse_nxt = 1'b0;
        w_rpt_nxt   = 1'b0;

        if (w_fall) begin
            w_state_nxt = ST_IDLE;
            w_rcnt_nxt  = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_rise) begin
                        w_pulse_nxt = 1'b1;
                        w_rcnt_nxt  = '0;
                        w_state_nxt = ST_DELAY;
                    end
                end
                ST_DELAY: begin
                    // With repeat disabled the counter is frozen and the state parks here.
                    if (c_REP_EN && w_tick) begin
                        if (r_rcnt == c_DELAY_LAST) begin
                            w_pulse_nxt = 1'b1;
                            w_rpt_nxt   = 1'b1;
                            w_rcnt_nxt  = '0;
                            w_state_nxt = ST_REPEAT;
                        end else begin
                            w_rcnt_nxt = r_rcnt + 1'b1;
                        end
                    end
                end
                ST_REPEAT: begin
                    if (w_tick) begin
                        if (r_rcnt == c_RATE_LAST) begin
                            w_pulse_nxt = 1'b1;
                            w_rpt_nxt   = 1'b1;
                            w_rcnt_nxt  = '0;
                        end else begin
                            w_rcnt_nxt = r_rcnt + 1'b1;
                        end
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_rcnt_nxt  = '0;
                end
            endcase
        end
    end

    assign level = r_level;
    assign pulse = r_pulse;
    assign rpt   = r_rpt;

endmodule
`default_nettype wire

// File: tb/tb_debounce_pulse.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_debounce_pulse                                              |
// | Brief    : Directed self-checking bench for debounce_pulse with          |
// |            TICK_DIV=4, STABLE_CNT=3, REPEAT_DELAY=5, REPEAT_RATE=2.      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_debounce_pulse;

    logic clk   = 1'b0;
    logic clr   = 1'b0;
    logic btn_n = 1'b1;

    logic level0, pulse0, rpt0;   // auto-repeat enabled
    logic level1, pulse1, rpt1;   // auto-repeat disabled

    int vectors     = 0;
    int miscompares = 0;
    int edge_n      = 0;          // posedges since the last clr release

    debounce_pulse #(
        .TICK_DIV(4), .STABLE_CNT(3), .ACTIVE_LOW(1),
        .REPEAT_EN(1), .REPEAT_DELAY(5), .REPEAT_RATE(2)
    ) dut_rep (
        .clk(clk), .clr(clr), .btn_n(btn_n),
        .level(level0), .pulse(pulse0), .rpt(rpt0)
    );

    debounce_pulse #(
        .TICK_DIV(4), .STABLE_CNT(3), .ACTIVE_LOW(1),
        .REPEAT_EN(0), .REPEAT_DELAY(5), .REPEAT_RATE(2)
    ) dut_norep (
        .clk(clk), .clr(clr), .btn_n(btn_n),
        .level(level1), .pulse(pulse1), .rpt(rpt1)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    // Advance one clock; observe #1 after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    // Ticks take effect on edges that are multiples of 4. A pin change made just after
    // edge e is seen as s from edge e+2; the first usable tick edge is the first
    // multiple of 4 at or after e+3, and the level moves two ticks (8 edges) later.
    function automatic int exp_edge(input int e);
        return ((e + 6) / 4) * 4 + 8;
    endfunction

    // Bounded wait for level0 to rise; returns the edge number or ok=0 on timeout.
    task automatic wait_rise(output int e, output bit ok);
        ok = 1'b0;
        e  = -1000;
        for (int i = 0; i < 30; i++) begin
            step();
            if (level0 === 1'b1) begin
                e  = edge_n;
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Release the button and let both instances return to idle.
    task automatic settle();
        btn_n = 1'b1;
        repeat (24) step();
    endtask

    task automatic test_reset();
        int bad;
        @(posedge clk);
        #1;
        clr = 1'b1;
        #1;
        vectors++;
        if ({level0, pulse0, rpt0} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_async_rep: got %b required 000", {level0, pulse0, rpt0});
        end
        vectors++;
        if ({level1, pulse1, rpt1} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_async_norep: got %b required 000", {level1, pulse1, rpt1});
        end
        repeat (3) step();
        clr    = 1'b0;
        edge_n = 0;
        bad    = 0;
        repeat (20) begin
            step();
            if ({level0, pulse0, rpt0, level1, pulse1, rpt1} !== 6'b0) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL reset_idle: got %0d active cycles required 0", bad);
        end
    endtask

    task automatic test_clean_press();
        int e_start, e0, e_r, ef, p_init0, p_all1, p_rel1, p_after;
        bit ok;
        e_start = edge_n;
        btn_n   = 1'b0;
        wait_rise(e0, ok);
        vectors++;
        if (!ok || e0 != exp_edge(e_start)) begin
            miscompares++;
            $display("FAIL press_latency: got %0d required %0d", e0 - e_start, exp_edge(e_start) - e_start);
        end
        vectors++;
        if ({pulse0, rpt0} !== 2'b10) begin
            miscompares++;
            $display("FAIL press_pulse: got pulse,rpt=%b required 10", {pulse0, rpt0});
        end
        p_init0 = (pulse0 === 1'b1 && rpt0 === 1'b0) ? 1 : 0;
        p_all1  = (pulse1 === 1'b1) ? 1 : 0;
        while (edge_n < e_start + 60) begin
            step();
            if (pulse0 === 1'b1 && rpt0 === 1'b0) p_init0++;
            if (pulse1 === 1'b1) p_all1++;
        end
        vectors++;
        if (p_init0 != 1) begin
            miscompares++;
            $display("FAIL press_initial_count: got %0d required 1", p_init0);
        end
        vectors++;
        if (p_all1 != 1) begin
            miscompares++;
            $display("FAIL press_norep_count: got %0d required 1", p_all1);
        end
        e_r    = edge_n;
        btn_n  = 1'b1;
        ef     = -1000;
        p_rel1 = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (pulse1 === 1'b1) p_rel1++;
            if (level0 === 1'b0) begin
                ef = edge_n;
                break;
            end
        end
        vectors++;
        if (ef != exp_edge(e_r)) begin
            miscompares++;
            $display("FAIL release_latency: got %0d required %0d", ef - e_r, exp_edge(e_r) - e_r);
        end
        vectors++;
        if (pulse0 !== 1'b0 || p_rel1 != 0) begin
            miscompares++;
            $display("FAIL release_pulse: got pulse0=%b norep_pulses=%0d required 0 and 0", pulse0, p_rel1);
        end
        p_after = 0;
        repeat (10) begin
            step();
            if (pulse0 !== 1'b0 || pulse1 !== 1'b0) p_after++;
        end
        vectors++;
        if (p_after != 0) begin
            miscompares++;
            $display("FAIL release_quiet: got %0d pulses required 0", p_after);
        end
    endtask

    task automatic test_bounce();
        int lv, np;
        lv = 0;
        np = 0;
        for (int i = 0; i < 200; i++) begin
            if (i % 5 == 0) btn_n = ~btn_n;
            step();
            if (level0 !== 1'b0 || level1 !== 1'b0) lv++;
            if (pulse0 !== 1'b0 || pulse1 !== 1'b0) np++;
        end
        btn_n = 1'b1;
        repeat (20) begin
            step();
            if (level0 !== 1'b0 || level1 !== 1'b0) lv++;
            if (pulse0 !== 1'b0 || pulse1 !== 1'b0) np++;
        end
        vectors++;
        if (lv != 0) begin
            miscompares++;
            $display("FAIL bounce_level: got %0d pressed cycles required 0", lv);
        end
        vectors++;
        if (np != 0) begin
            miscompares++;
            $display("FAIL bounce_pulses: got %0d required 0", np);
        end
    endtask

    task automatic test_auto_repeat();
        int e_start, e0, np, k;
        bit ok, exp_p, exp_r;
        e_start = edge_n;
        btn_n   = 1'b0;
        wait_rise(e0, ok);
        vectors++;
        if (!ok || e0 != exp_edge(e_start)) begin
            miscompares++;
            $display("FAIL repeat_rise: got %0d required %0d", e0 - e_start, exp_edge(e_start) - e_start);
        end
        np = 0;
        for (int d = 0; d <= 120; d++) begin
            if (d > 0) step();
            k     = d / 4;
            exp_p = (d % 4 == 0) && (k == 0 || (k >= 5 && (k - 5) % 2 == 0));
            exp_r = exp_p && (k != 0);
            if (pulse0 === 1'b1) np++;
            vectors++;
            if ({pulse0, rpt0} !== {exp_p, exp_r}) begin
                miscompares++;
                $display("FAIL repeat_seq at edge+%0d: got pulse,rpt=%b required %b", d, {pulse0, rpt0}, {exp_p, exp_r});
            end
        end
        vectors++;
        if (np != 14) begin
            miscompares++;
            $display("FAIL repeat_count: got %0d required 14", np);
        end
        settle();
    endtask

    task automatic test_repeat_disabled();
        int e0, np, nr;
        bit ok;
        btn_n = 1'b0;
        wait_rise(e0, ok);
        vectors++;
        if (!ok || {level1, pulse1, rpt1} !== 3'b110) begin
            miscompares++;
            $display("FAIL norep_rise: got level,pulse,rpt=%b required 110", {level1, pulse1, rpt1});
        end
        np = 0;
        nr = 0;
        for (int d = 0; d <= 120; d++) begin
            if (d > 0) step();
            if (pulse1 === 1'b1) np++;
            if (rpt1 !== 1'b0) nr++;
        end
        vectors++;
        if (np != 1 || nr != 0) begin
            miscompares++;
            $display("FAIL norep_count: got pulses=%0d rpt=%0d required 1 and 0", np, nr);
        end
        settle();
    endtask

    task automatic test_reset_mid_repeat();
        int e0;
        bit ok, exp_l, exp_p, exp_r;
        btn_n = 1'b0;
        wait_rise(e0, ok);
        repeat (26) step();
        clr = 1'b1;
        #1;
        vectors++;
        if ({level0, pulse0, rpt0, level1, pulse1, rpt1} !== 6'b0) begin
            miscompares++;
            $display("FAIL midreset_async: got %b required 000000", {level0, pulse0, rpt0, level1, pulse1, rpt1});
        end
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++;
            if ({level0, pulse0, rpt0, level1, pulse1, rpt1} !== 6'b0) begin
                miscompares++;
                $display("FAIL midreset_hold cycle %0d: got %b required 000000", i, {level0, pulse0, rpt0, level1, pulse1, rpt1});
            end
        end
        clr    = 1'b0;
        edge_n = 0;
        for (int e = 1; e < 40; e++) begin
            step();
            exp_l = (e >= 12);
            exp_p = (e == 12) || (e == 32);
            exp_r = (e == 32);
            vectors++;
            if ({level0, pulse0, rpt0} !== {exp_l, exp_p, exp_r}) begin
                miscompares++;
                $display("FAIL midreset_restart edge %0d: got level,pulse,rpt=%b required %b", e, {level0, pulse0, rpt0}, {exp_l, exp_p, exp_r});
            end
        end
        settle();
    endtask

    task automatic test_release_collide();
        int e0;
        bit ok, exp_l, exp_p;
        btn_n = 1'b0;
        wait_rise(e0, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL collide_rise: got no rise required rise");
        end
        for (int d = 1; d <= 50; d++) begin
            step();
            exp_l = (d < 36);
            exp_p = (d == 20) || (d == 28);
            vectors++;
            if ({level0, pulse0, rpt0} !== {exp_l, exp_p, exp_p}) begin
                miscompares++;
                $display("FAIL collide_seq at edge+%0d: got level,pulse,rpt=%b required %b", d, {level0, pulse0, rpt0}, {exp_l, exp_p, exp_p});
            end
            if (d == 24) btn_n = 1'b1;
        end
        // A fresh press must start from idle: initial pulse, not a repeat.
        btn_n = 1'b0;
        wait_rise(e0, ok);
        vectors++;
        if (!ok || {pulse0, rpt0} !== 2'b10) begin
            miscompares++;
            $display("FAIL collide_repress: got pulse,rpt=%b required 10", {pulse0, rpt0});
        end
        settle();
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_auto_repeat();
        test_repeat_disabled();
        test_reset_mid_repeat();
        test_release_collide();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/debounce_pulse.md
# debounce_pulse

Conditions one raw push-button into clean control signals for the counter chain. It synchronises the asynchronous button, debounces it with a sampled stability integrator, and emits a single-clock `pulse` per press, plus optional auto-repeat pulses while the button is held. `pulse` drives the counter's count-enable (`cin`) directly in the `clk` domain, so no divided clock is used downstream.

## Interface
- `TICK_DIV`, 50000: clk cycles per sample tick (1 ms at 50 MHz); ≥2
- `STABLE_CNT`, 8: consecutive ticks of unchanged sample needed to flip `level`; ≥1
- `ACTIVE_LOW`, 1: 1 means a pressed button reads 0 on `btn_n`
- `REPEAT_EN`, 1: enables auto-repeat
- `REPEAT_DELAY`, 500: ticks from press to first repeat pulse; ≥1
- `REPEAT_RATE`, 100: ticks between subsequent repeat pulses; ≥1

- `clk`  in  1  system clock; only clock
- `clr`  in  1  asynchronous, active-high reset
- `btn_n`  in  1  raw button, asynchronous to `clk`
- `level`  out  1  debounced pressed state (1 = pressed)
- `pulse`  out  1  one-cycle strobe: press or repeat
- `rpt`  out  1  qualifies `pulse`: 1 when the strobe is a repeat, 0 on the initial press

## Operation
- Synchroniser: 2 flops. They reset to the released value (1 if `ACTIVE_LOW`). The output is normalised to `s` (1 = pressed).
- Prescaler: counts 0..`TICK_DIV`-1 and wraps to 0. `tick` is high for the one cycle where count = `TICK_DIV`-1.
- Integrator, evaluated only on `tick`:
  - If `s` ≠ `level`: `stab` increments.
  - If `s` = `level`: `stab` clears.
  - When an increment would reach `STABLE_CNT`: `level` toggles and `stab` clears.
  - Any single agreeing sample restarts the count.
- FSM states IDLE, DELAY, REPEAT, with repeat counter `rcnt`:
  - IDLE: on `level` 0→1, assert `pulse` with `rpt`=0, clear `rcnt`, go to DELAY.
  - DELAY: on `tick`, `rcnt`++. When `REPEAT_EN`=1 and `rcnt` = `REPEAT_DELAY`-1 on a `tick`: `pulse`, `rpt`=1, `rcnt`=0, go to REPEAT. When `REPEAT_EN`=0, stay in DELAY and stop counting.
  - REPEAT: on `tick`, `rcnt`++. When `rcnt` = `REPEAT_RATE`-1 on a `tick`: `pulse`, `rpt`=1, `rcnt`=0.
  - Any state: when `level` falls, go to IDLE, clear `rcnt`, no pulse. Release never generates a pulse.
- Simultaneous events: `level` falling on the same `tick` that would fire a repeat gives no pulse; the fall wins.
- Widths: `$clog2` of each terminal value. Counters never exceed their terminal value. No overflow is possible.

## Timing
- Reset values (asynchronous, immediate on `clr` rise):
  - `level`, `pulse`, `rpt` = 0
  - FSM = IDLE
  - prescaler, `stab`, `rcnt` = 0
  - synchroniser = released value
- All outputs are registered. `pulse` and `rpt` are high for exactly one clk cycle and are low outside pulses.
- Press latency: 2 synchroniser cycles, then `STABLE_CNT` ticks, i.e. 2 + (`STABLE_CNT`-1)·`TICK_DIV` + up to `TICK_DIV` cycles.
- `level` rising and the initial `pulse` appear on the same clk edge.
- Repeat pulse n≥1 lands on tick `REPEAT_DELAY` + (n-1)·`REPEAT_RATE`, counted in ticks after `level` rose.
- Release latency is the same formula as press latency.
- Reset mid-operation: a button held across `clr` deassertion is treated as a fresh press. After `STABLE_CNT` ticks it produces one initial pulse, and the repeat sequence restarts from DELAY.
- Glitches shorter than one tick period may be missed entirely. This is intended.

## Structure
- Shared package `ui_pkg` holds:
  - the FSM state enum (`ST_IDLE`, `ST_DELAY`, `ST_REPEAT`)
  - the default tick constant `TICK_1MS` = 50000
- One sub-module, `tick_gen`: parameter `TICK_DIV`, ports (`clk`, `clr`, `tick`). It is reused later by display scanning.
- Synchroniser, integrator and FSM stay in `debounce_pulse`.

## Test plan
All scenarios use `TICK_DIV`=4, `STABLE_CNT`=3, `REPEAT_DELAY`=5, `REPEAT_RATE`=2, `ACTIVE_LOW`=1.
1. **Clean press:** drive `btn_n` 1→0 and hold 60 cycles → `level` rises within 2+8..2+12 cycles; exactly one `pulse` with `rpt`=0. Then drive `btn_n` →1 → `level` falls after the same latency; no pulse.
2. **Bounce:** toggle `btn_n` every 5 cycles for 200 cycles → `level` stays 0; zero pulses.
3. **Auto-repeat:** hold pressed for 30 ticks after `level` rises → 14 pulses total. The first has `rpt`=0; the rest (`rpt`=1) fall at ticks 5, 7, …, 29.
4. **`REPEAT_EN`=0:** hold pressed for 30 ticks → exactly 1 pulse; `rpt` never set.
5. **Reset mid-REPEAT:** assert `clr` for 3 cycles while held → all outputs 0 asynchronously. Release `clr` with the button still held → after 3 ticks `level`=1 and one `pulse` with `rpt`=0; the next repeat comes 5 ticks later.
6. **Release collides with repeat:** release timed so `level` falls on the tick of the 3rd repeat → no 3rd repeat pulse; FSM goes to IDLE.
